// File: rtl/mul_seq_pkg.sv
// Shared definitions for the iterative multiply sequencer.
// Contents:
//   WORD                - default datapath width (64)
//   ALU_ADD / ALU_PASS  - ALU control encodings that the sequencer drives
//   mul_state_e         - 2-bit sequencer state encoding (IDLE/RUN/DONE)
//   mul_last_iter()     - true when the multiplier has no set bits above bit 0
package mul_seq_pkg;

    localparam int WORD = 64;

    // LEGv8 ALU control codes: add, and pass operand b through.
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_PASS = 4'b0111;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_RUN  = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_e;

    // The loop ends once the multiplier would be zero after this shift.
    // Callers pass mp[W-1:1]; evaluating at the package's widest width keeps
    // the helper width-agnostic (unused upper bits are zero-extended).
    function automatic logic mul_last_iter(input logic [WORD-2:0] mp_upper);
        return (mp_upper == {(WORD-1){1'b0}});
    endfunction

endpackage

// File: rtl/mul_seq.sv
// mul_seq: iterative shift-and-add multiplier producing the low WIDTH bits
// of mcand*mplier. It has no adder of its own; while in RUN it drives an
// external ALU with ALU_ADD on operands (acc, mc) and captures alu_out.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   start               - request, sampled only in IDLE (ignored while busy)
//   mcand, mplier       - operands, sampled with start
//   busy                - high whenever the sequencer is not IDLE
//   done                - one-cycle pulse; product valid
//   product             - result, held until the next accepted start
//   alu_a, alu_b        - ALU operands from the acc / shifted-mcand registers
//   alu_ctl             - ALU_ADD in RUN, ALU_PASS otherwise
//   alu_out             - ALU result (flags are not used)
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = WORD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] alu_out
);

    mul_state_e       state_r;
    mul_state_e       next_state_s;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] mc_r;
    logic [WIDTH-1:0] mp_r;
    logic             busy_r;
    logic             done_r;
    logic [3:0]       alu_ctl_r;
    logic [WORD-2:0]  mp_upper_s;
    logic             last_iter_s;

    // Multiplier bits above bit 0, zero-extended to the helper's width.
    always_comb begin
        mp_upper_s = {(WORD-1){1'b0}};
        mp_upper_s[WIDTH-2:0] = mp_r[WIDTH-1:1];
        last_iter_s = mul_last_iter(mp_upper_s);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= MUL_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a zero multiplier skips RUN entirely.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            MUL_IDLE: begin
                if (start) begin
                    if (mplier == {WIDTH{1'b0}}) begin
                        next_state_s = MUL_DONE;
                    end else begin
                        next_state_s = MUL_RUN;
                    end
                end else begin
                    next_state_s = MUL_IDLE;
                end
            end
            MUL_RUN: begin
                if (last_iter_s) begin
                    next_state_s = MUL_DONE;
                end else begin
                    next_state_s = MUL_RUN;
                end
            end
            MUL_DONE: next_state_s = MUL_IDLE;
            default:  next_state_s = MUL_IDLE;
        endcase
    end

    // Datapath: load operands on an accepted start, then one shift-and-add
    // step per RUN cycle. Outside those cases acc holds the finished product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r <= {WIDTH{1'b0}};
            mc_r  <= {WIDTH{1'b0}};
            mp_r  <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                MUL_IDLE: begin
                    if (start) begin
                        acc_r <= {WIDTH{1'b0}};
                        mc_r  <= mcand;
                        mp_r  <= mplier;
                    end else begin
                        acc_r <= acc_r;
                        mc_r  <= mc_r;
                        mp_r  <= mp_r;
                    end
                end
                MUL_RUN: begin
                    if (mp_r[0]) begin
                        acc_r <= alu_out;
                    end else begin
                        acc_r <= acc_r;
                    end
                    mc_r <= {mc_r[WIDTH-2:0], 1'b0};
                    mp_r <= {1'b0, mp_r[WIDTH-1:1]};
                end
                default: begin
                    acc_r <= acc_r;
                    mc_r  <= mc_r;
                    mp_r  <= mp_r;
                end
            endcase
        end
    end

    // Status and ALU control are registered from the next state so they
    // line up exactly with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            alu_ctl_r <= ALU_PASS;
        end else begin
            busy_r    <= (next_state_s != MUL_IDLE);
            done_r    <= (next_state_s == MUL_DONE);
            alu_ctl_r <= (next_state_s == MUL_RUN) ? ALU_ADD : ALU_PASS;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign alu_ctl = alu_ctl_r;
    assign alu_a   = acc_r;
    assign alu_b   = mc_r;
    // product is the accumulator itself, so it is stable throughout DONE.
    assign product = acc_r;

endmodule
